// File: rtl/mc_cu.sv
// Multi-cycle MIPS control unit: IF/ID/EXE/MEM/WB sequencer driving
// write enables, mux selects and ALU ops for a shared-memory datapath.
module mc_cu (
    input  logic       clock,
    input  logic       resetn,
    input  logic [5:0] op,
    input  logic [5:0] func,
    input  logic       z,
    input  logic       mem_ready,
    output logic       wpc,
    output logic       wir,
    output logic       wmem,
    output logic       wreg,
    output logic       iord,
    output logic       regrt,
    output logic       m2reg,
    output logic       jal,
    output logic       shift,
    output logic       sext,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [3:0] aluc,
    output logic [1:0] pcsource,
    output logic [2:0] state,
    output logic       illegal
);

    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EXE = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4
    } state_t;

    state_t state_q, state_d;

    logic r_type;
    logic i_add, i_sub, i_and, i_or, i_xor;
    logic i_sll, i_srl, i_sra, i_jr;
    logic i_addi, i_andi, i_ori, i_xori, i_lui;
    logic i_lw, i_sw, i_beq, i_bne, i_j, i_jal;
    logic r_alu, i_alu, decoded;

    assign r_type = (op == 6'b000000);
    assign i_add  = r_type & (func == 6'b100000);
    assign i_sub  = r_type & (func == 6'b100010);
    assign i_and  = r_type & (func == 6'b100100);
    assign i_or   = r_type & (func == 6'b100101);
    assign i_xor  = r_type & (func == 6'b100110);
    assign i_sll  = r_type & (func == 6'b000000);
    assign i_srl  = r_type & (func == 6'b000010);
    assign i_sra  = r_type & (func == 6'b000011);
    assign i_jr   = r_type & (func == 6'b001000);
    assign i_addi = (op == 6'b001000);
    assign i_andi = (op == 6'b001100);
    assign i_ori  = (op == 6'b001101);
    assign i_xori = (op == 6'b001110);
    assign i_lui  = (op == 6'b001111);
    assign i_lw   = (op == 6'b100011);
    assign i_sw   = (op == 6'b101011);
    assign i_beq  = (op == 6'b000100);
    assign i_bne  = (op == 6'b000101);
    assign i_j    = (op == 6'b000010);
    assign i_jal  = (op == 6'b000011);

    assign r_alu = i_add | i_sub | i_and | i_or | i_xor
                 | i_sll | i_srl | i_sra;
    assign i_alu = i_addi | i_andi | i_ori | i_xori | i_lui;
    assign decoded = r_alu | i_jr | i_alu | i_lw | i_sw
                   | i_beq | i_bne | i_j | i_jal;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IF;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

    always_comb begin
        state_d  = state_q;
        wpc      = 1'b0;
        wir      = 1'b0;
        wmem     = 1'b0;
        wreg     = 1'b0;
        iord     = 1'b0;
        regrt    = 1'b0;
        m2reg    = 1'b0;
        jal      = 1'b0;
        shift    = 1'b0;
        sext     = 1'b0;
        alusrca  = 1'b0;
        alusrcb  = 2'b00;
        aluc     = 4'b0000;
        pcsource = 2'b00;
        illegal  = 1'b0;
        unique case (state_q)
            S_IF: begin
                alusrcb = 2'b01;
                if (mem_ready) begin
                    wpc     = 1'b1;
                    wir     = 1'b1;
                    state_d = S_ID;
                end
            end
            S_ID: begin
                // ALU computes PC+4 + (imm<<2) so the branch target is latched
                alusrcb = 2'b11;
                sext    = 1'b1;
                state_d = S_EXE;
                unique case (1'b1)
                    i_j: begin
                        wpc      = 1'b1;
                        pcsource = 2'b11;
                        state_d  = S_IF;
                    end
                    i_jal: begin
                        wpc      = 1'b1;
                        pcsource = 2'b11;
                        wreg     = 1'b1;
                        jal      = 1'b1;
                        state_d  = S_IF;
                    end
                    i_jr: begin
                        wpc      = 1'b1;
                        pcsource = 2'b10;
                        state_d  = S_IF;
                    end
                    !decoded: begin
                        illegal = 1'b1;
                        state_d = S_IF;
                    end
                    default: ;
                endcase
            end
            S_EXE: begin
                alusrca = 1'b1;
                state_d = S_IF;
                unique case (1'b1)
                    r_alu: begin
                        shift   = i_sll | i_srl | i_sra;
                        state_d = S_WB;
                        unique case (1'b1)
                            i_sub:   aluc = 4'b0100;
                            i_and:   aluc = 4'b0001;
                            i_or:    aluc = 4'b0101;
                            i_xor:   aluc = 4'b0010;
                            i_sll:   aluc = 4'b0011;
                            i_srl:   aluc = 4'b0111;
                            i_sra:   aluc = 4'b1111;
                            default: aluc = 4'b0000;
                        endcase
                    end
                    i_alu: begin
                        alusrcb = 2'b10;
                        sext    = i_addi;
                        state_d = S_WB;
                        unique case (1'b1)
                            i_andi:  aluc = 4'b0001;
                            i_ori:   aluc = 4'b0101;
                            i_xori:  aluc = 4'b0010;
                            i_lui:   aluc = 4'b0110;
                            default: aluc = 4'b0000;
                        endcase
                    end
                    i_lw | i_sw: begin
                        alusrcb = 2'b10;
                        sext    = 1'b1;
                        state_d = S_MEM;
                    end
                    i_beq | i_bne: begin
                        aluc = 4'b0100;
                        if ((i_beq & z) | (i_bne & ~z)) begin
                            wpc      = 1'b1;
                            pcsource = 2'b01;
                        end
                    end
                    default: ;
                endcase
            end
            S_MEM: begin
                iord = 1'b1;
                wmem = i_sw;
                if (mem_ready) begin
                    state_d = i_lw ? S_WB : S_IF;
                end
            end
            S_WB: begin
                wreg    = 1'b1;
                regrt   = i_alu | i_lw;
                m2reg   = i_lw;
                state_d = S_IF;
            end
            default: state_d = S_IF;
        endcase
        // Reset must suppress every write even if inputs look active
        if (!resetn) begin
            wpc     = 1'b0;
            wir     = 1'b0;
            wmem    = 1'b0;
            wreg    = 1'b0;
            illegal = 1'b0;
        end
    end

endmodule

// File: tb/tb_mc_cu.sv
// Scoreboard bench for mc_cu: stimulus pushes per-cycle expectations,
// a negedge monitor pops and compares the cared-about output fields.
module tb_mc_cu;

    logic       clock = 1'b0;
    logic       resetn;
    logic [5:0] op;
    logic [5:0] func;
    logic       z;
    logic       mem_ready;
    logic       wpc, wir, wmem, wreg, iord, regrt, m2reg, jal;
    logic       shift, sext, alusrca, illegal;
    logic [1:0] alusrcb, pcsource;
    logic [3:0] aluc;
    logic [2:0] state;

    mc_cu dut (
        .clock(clock), .resetn(resetn), .op(op), .func(func),
        .z(z), .mem_ready(mem_ready),
        .wpc(wpc), .wir(wir), .wmem(wmem), .wreg(wreg),
        .iord(iord), .regrt(regrt), .m2reg(m2reg), .jal(jal),
        .shift(shift), .sext(sext), .alusrca(alusrca),
        .alusrcb(alusrcb), .aluc(aluc), .pcsource(pcsource),
        .state(state), .illegal(illegal)
    );

    always #5 clock = ~clock;

    localparam int P_ST   = 20;
    localparam int P_WE   = 16;
    localparam int P_IORD = 15;
    localparam int P_RGRT = 14;
    localparam int P_M2R  = 13;
    localparam int P_JAL  = 12;
    localparam int P_SH   = 11;
    localparam int P_SEXT = 10;
    localparam int P_ASA  = 9;
    localparam int P_ASB  = 7;
    localparam int P_ALUC = 3;
    localparam int P_PCS  = 1;
    localparam int P_ILL  = 0;

    typedef struct {
        string       nm;
        logic [22:0] v;
        logic [22:0] m;
    } exp_t;

    exp_t        q[$];
    exp_t        cur;
    exp_t        e;
    logic [22:0] got;
    int          n_cmp = 0;
    int          n_err = 0;

    assign got = {state, wpc, wir, wmem, wreg, iord, regrt, m2reg,
                  jal, shift, sext, alusrca, alusrcb, aluc,
                  pcsource, illegal};

    always @(negedge clock) begin
        if (q.size() > 0) begin
            e = q.pop_front();
            n_cmp++;
            if ((got & e.m) !== (e.v & e.m)) begin
                n_err++;
                $display("FAIL %s: got %06h need %06h (mask %06h)",
                         e.nm, got & e.m, e.v & e.m, e.m);
            end
        end
    end

    task automatic fld(input int pos, input int w, input logic [3:0] val);
        for (int i = 0; i < w; i++) begin
            cur.v[pos+i] = val[i];
            cur.m[pos+i] = 1'b1;
        end
    endtask

    task automatic put(input string nm, input logic [2:0] st,
                       input logic [3:0] we, input logic ill);
        cur.nm = nm;
        cur.v  = '0;
        cur.m  = '0;
        fld(P_ST, 3, {1'b0, st});
        fld(P_WE, 4, we);
        fld(P_ILL, 1, ill);
    endtask

    task automatic go();
        q.push_back(cur);
        @(posedge clock);
        #1;
    endtask

    task automatic set_ins(input logic [5:0] o, input logic [5:0] f,
                           input logic zz);
        op   = o;
        func = f;
        z    = zz;
    endtask

    task automatic t_rst(input string nm);
        put(nm, 3'd0, 4'b0000, 1'b0);
        go();
    endtask

    task automatic t_if(input string nm, input logic mr);
        mem_ready = mr;
        put(nm, 3'd0, {mr, mr, 2'b00}, 1'b0);
        fld(P_IORD, 1, 4'd0);
        fld(P_ASA, 1, 4'd0);
        fld(P_ASB, 2, 4'd1);
        fld(P_ALUC, 4, 4'd0);
        fld(P_PCS, 2, 4'd0);
        go();
    endtask

    task automatic t_id(input string nm, input logic pc, input logic rg,
                        input logic jl, input logic [1:0] pcs,
                        input logic ill);
        put(nm, 3'd1, {pc, 2'b00, rg}, ill);
        fld(P_ASA, 1, 4'd0);
        fld(P_ASB, 2, 4'd3);
        fld(P_SEXT, 1, 4'd1);
        fld(P_ALUC, 4, 4'd0);
        fld(P_JAL, 1, {3'b000, jl});
        if (pc) fld(P_PCS, 2, {2'b00, pcs});
        go();
    endtask

    task automatic t_exe(input string nm, input logic pc,
                         input logic [1:0] asb, input logic [3:0] ac,
                         input logic sh, input logic sc, input logic sx);
        put(nm, 3'd2, {pc, 3'b000}, 1'b0);
        fld(P_ASA, 1, 4'd1);
        fld(P_ASB, 2, {2'b00, asb});
        fld(P_ALUC, 4, ac);
        fld(P_SH, 1, {3'b000, sh});
        if (sc) fld(P_SEXT, 1, {3'b000, sx});
        if (pc) fld(P_PCS, 2, 4'd1);
        go();
    endtask

    task automatic t_mem(input string nm, input logic mr, input logic wm);
        mem_ready = mr;
        put(nm, 3'd3, {2'b00, wm, 1'b0}, 1'b0);
        fld(P_IORD, 1, 4'd1);
        go();
    endtask

    task automatic t_wb(input string nm, input logic rt, input logic m2r);
        put(nm, 3'd4, 4'b0001, 1'b0);
        fld(P_RGRT, 1, {3'b000, rt});
        fld(P_M2R, 1, {3'b000, m2r});
        fld(P_JAL, 1, 4'd0);
        go();
    endtask

    initial begin
        resetn    = 1'b0;
        mem_ready = 1'b1;
        set_ins(6'b000000, 6'b100000, 1'b0);
        @(posedge clock);
        #1;
        t_rst("reset_hold");
        resetn = 1'b1;

        t_if("add_if_stall", 1'b0);
        t_if("add_if", 1'b1);
        mem_ready = 1'b0;
        t_id("add_id", 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
        t_exe("add_exe", 1'b0, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0);
        t_wb("add_wb", 1'b0, 1'b0);

        set_ins(6'b000000, 6'b100010, 1'b0);
        t_if("sub_if", 1'b1);
        t_id("sub_id", 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
        t_exe("sub_exe", 1'b0, 2'b00, 4'b0100, 1'b0, 1'b0, 1'b0);
        t_wb("sub_wb", 1'b0, 1'b0);

        set_ins(6'b000000, 6'b000011, 1'b0);
        t_if("sra_if", 1'b1);
        t_id("sra_id", 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
        t_exe("sra_exe", 1'b0, 2'b00, 4'b1111, 1'b1, 1'b0, 1'b0);
        t_wb("sra_wb", 1'b0, 1'b0);

        set_ins(6'b001101, 6'b000000, 1'b0);
        t_if("ori_if", 1'b1);
        t_id("ori_id", 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
        t_exe("ori_exe", 1'b0, 2'b10, 4'b0101, 1'b0, 1'b1, 1'b0);
        t_wb("ori_wb", 1'b1, 1'b0);

        set_ins(6'b001000, 6'b000000, 1'b0);
        t_if("addi_if", 1'b1);
        t_id("addi_id", 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
        t_exe("addi_exe", 1'b0, 2'b10, 4'b0000, 1'b0, 1'b1, 1'b1);
        t_wb("addi_wb", 1'b1, 1'b0);

        set_ins(6'b001111, 6'b000000, 1'b0);
        t_if("lui_if", 1'b1);
        t_id("lui_id", 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
        t_exe("lui_exe", 1'b0, 2'b10, 4'b0110, 1'b0, 1'b1, 1'b0);
        t_wb("lui_wb", 1'b1, 1'b0);

        set_ins(6'b100011, 6'b000000, 1'b0);
        t_if("lw_if", 1'b1);
        t_id("lw_id", 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
        t_exe("lw_exe", 1'b0, 2'b10, 4'b0000, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) t_mem("lw_mem_wait", 1'b0, 1'b0);
        t_mem("lw_mem_done", 1'b1, 1'b0);
        t_wb("lw_wb", 1'b1, 1'b1);

        set_ins(6'b000100, 6'b000000, 1'b1);
        t_if("beq_t_if", 1'b1);
        t_id("beq_t_id", 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
        t_exe("beq_t_exe", 1'b1, 2'b00, 4'b0100, 1'b0, 1'b0, 1'b0);

        set_ins(6'b000100, 6'b000000, 1'b0);
        t_if("beq_n_if", 1'b1);
        t_id("beq_n_id", 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
        t_exe("beq_n_exe", 1'b0, 2'b00, 4'b0100, 1'b0, 1'b0, 1'b0);

        set_ins(6'b000101, 6'b000000, 1'b0);
        t_if("bne_t_if", 1'b1);
        t_id("bne_t_id", 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
        t_exe("bne_t_exe", 1'b1, 2'b00, 4'b0100, 1'b0, 1'b0, 1'b0);

        set_ins(6'b000011, 6'b000000, 1'b0);
        t_if("jal_if", 1'b1);
        t_id("jal_id", 1'b1, 1'b1, 1'b1, 2'b11, 1'b0);

        set_ins(6'b000010, 6'b000000, 1'b0);
        t_if("j_if", 1'b1);
        t_id("j_id", 1'b1, 1'b0, 1'b0, 2'b11, 1'b0);

        set_ins(6'b000000, 6'b001000, 1'b0);
        t_if("jr_if", 1'b1);
        t_id("jr_id", 1'b1, 1'b0, 1'b0, 2'b10, 1'b0);

        set_ins(6'b111111, 6'b000000, 1'b0);
        t_if("ill_if", 1'b1);
        t_id("ill_id", 1'b0, 1'b0, 1'b0, 2'b00, 1'b1);

        set_ins(6'b101011, 6'b000000, 1'b0);
        t_if("sw_if", 1'b1);
        t_id("sw_id", 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
        t_exe("sw_exe", 1'b0, 2'b10, 4'b0000, 1'b0, 1'b1, 1'b1);
        t_mem("sw_mem", 1'b1, 1'b1);

        t_if("sw2_if", 1'b1);
        t_id("sw2_id", 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
        t_exe("sw2_exe", 1'b0, 2'b10, 4'b0000, 1'b0, 1'b1, 1'b1);
        t_mem("sw2_mem_wait", 1'b0, 1'b1);
        resetn    = 1'b0;
        mem_ready = 1'b1;
        t_rst("rst_mid_sw");
        t_rst("rst_hold2");
        resetn = 1'b1;
        t_if("resume_if", 1'b1);
        t_id("resume_id", 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);

        @(negedge clock);
        @(negedge clock);
        n_cmp++;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d left, need 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: sim time %0t exceeded", $time);
        $fatal(1, "timeout");
    end

endmodule
